// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard unit for a 5-stage MIPS pipeline. Tracks shadow EX/MEM and
// MEM/WB destination state and produces forwarding selects, load-use stalls and mul/div holds.
module fwd_hazard_ctrl #(
    parameter int AW        = 5,
    parameter int MD_LAT    = 4,
    parameter int FWD_WB_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic          ex_md_start,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [1:0]    fwd_st,
    output logic          stall,
    output logic          bubble,
    output logic          md_busy
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    localparam logic       MD_MULTI = (MD_LAT > 1);
    localparam logic       WB_EN    = (FWD_WB_EN != 0);
    localparam logic [3:0] MD_LOAD  = 4'(MD_LAT - 1);
    localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};

    md_state_t     state_r;
    logic [3:0]    cnt_r;
    logic [AW-1:0] mem_rd_r;
    logic          mem_rw_r;
    logic          mem_ld_r;
    logic [AW-1:0] wb_rd_r;
    logic          wb_rw_r;

    logic          md_busy_s;
    logic          luh_s;
    logic          luh_eff_s;
    logic [1:0]    sel_a_s;
    logic [1:0]    sel_b_s;

    // EX/MEM wins over MEM/WB because it holds the younger value; loads in MEM cannot forward yet.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] m_rd,
        input logic          m_rw,
        input logic          m_ld,
        input logic [AW-1:0] w_rd,
        input logic          w_rw
    );
        logic [1:0] sel;
        if (m_rw && (m_rd != ZERO_REG) && (m_rd == src) && !m_ld) begin
            sel = 2'b01;
        end else if (WB_EN && w_rw && (w_rd != ZERO_REG) && (w_rd == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard and forwarding decode from shadow state and the current EX/ID fields.
    always_comb begin
        md_busy_s = (state_r == BUSY) || (ex_md_start && MD_MULTI);
        luh_s     = ex_memread && (ex_rd != ZERO_REG) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        luh_eff_s = luh_s && !md_busy_s;
        sel_a_s   = fwd_sel(ex_rs, mem_rd_r, mem_rw_r, mem_ld_r, wb_rd_r, wb_rw_r);
        sel_b_s   = fwd_sel(ex_rt, mem_rd_r, mem_rw_r, mem_ld_r, wb_rd_r, wb_rw_r);
    end

    // Output drive; everything is held low while reset is asserted.
    always_comb begin
        if (rst) begin
            fwd_a   = 2'b00;
            fwd_b   = 2'b00;
            fwd_st  = 2'b00;
            stall   = 1'b0;
            bubble  = 1'b0;
            md_busy = 1'b0;
        end else begin
            fwd_a   = sel_a_s;
            fwd_b   = sel_b_s;
            fwd_st  = ex_memwrite ? sel_b_s : 2'b00;
            stall   = luh_eff_s || md_busy_s;
            bubble  = luh_eff_s;
            md_busy = md_busy_s;
        end
    end

    // Shadow EX/MEM and MEM/WB destination state; a held mul/div sends a bubble into MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_r <= ZERO_REG;
            mem_rw_r <= 1'b0;
            mem_ld_r <= 1'b0;
            wb_rd_r  <= ZERO_REG;
            wb_rw_r  <= 1'b0;
        end else begin
            wb_rd_r <= mem_rd_r;
            wb_rw_r <= mem_rw_r;
            if (md_busy_s) begin
                mem_rd_r <= ZERO_REG;
                mem_rw_r <= 1'b0;
                mem_ld_r <= 1'b0;
            end else begin
                mem_rd_r <= ex_rd;
                mem_rw_r <= ex_regwrite;
                mem_ld_r <= ex_memread;
            end
        end
    end

    // Mul/div sequencer: the start cycle plus MD_LAT-1 BUSY cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ex_md_start && MD_MULTI) begin
                        state_r <= BUSY;
                        cnt_r   <= MD_LOAD;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end
                end
                BUSY: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= IDLE;
                        cnt_r   <= 4'd0;
                    end else begin
                        state_r <= BUSY;
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a default instance and a FWD_WB_EN=0, MD_LAT=1
// instance share stimulus; a reference model queues expectations, a monitor checks them.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;

    typedef struct {
        int ers, ert, erd, irs, irt;
        bit rw, mr, mw, md, urt, r;
    } stim_t;

    typedef struct {
        logic [8:0] exp0;
        logic [8:0] exp1;
        int         idx;
    } exp_t;

    typedef struct {
        int rd;
        bit rw, ld;
    } stage_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rd = '0;
    logic id_uses_rt = 1'b0, ex_regwrite = 1'b0, ex_memread = 1'b0;
    logic ex_memwrite = 1'b0, ex_md_start = 1'b0;

    logic [1:0] fa0, fb0, fs0, fa1, fb1, fs1;
    logic st0, bu0, mb0, st1, bu1, mb1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    exp_t exp_q[$];

    // reference model state per instance
    int     lat[2] = '{4, 1};
    bit     wben[2] = '{1'b1, 1'b0};
    stage_t mem_s[2];
    stage_t wb_s[2];
    int     busy_left[2];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.AW(AW), .MD_LAT(4), .FWD_WB_EN(1)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_md_start(ex_md_start),
        .fwd_a(fa0), .fwd_b(fb0), .fwd_st(fs0), .stall(st0), .bubble(bu0), .md_busy(mb0)
    );

    fwd_hazard_ctrl #(.AW(AW), .MD_LAT(1), .FWD_WB_EN(0)) dut_nowb (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_md_start(ex_md_start),
        .fwd_a(fa1), .fwd_b(fb1), .fwd_st(fs1), .stall(st1), .bubble(bu1), .md_busy(mb1)
    );

    function automatic stim_t mk(int ers, int ert, int erd, bit rw, bit mr, bit mw, bit md,
                                 int irs, int irt, bit urt, bit r);
        stim_t s;
        s.ers = ers; s.ert = ert; s.erd = erd; s.rw = rw; s.mr = mr; s.mw = mw;
        s.md = md; s.irs = irs; s.irt = irt; s.urt = urt; s.r = r;
        return s;
    endfunction

    // Where does the newest value of register src live, according to the rules?
    function automatic int src_of(int k, int src);
        if (src == 0) return 0;
        if (mem_s[k].rw && mem_s[k].rd == src && !mem_s[k].ld) return 1;
        if (wben[k] && wb_s[k].rw && wb_s[k].rd == src) return 2;
        return 0;
    endfunction

    function automatic logic [8:0] predict(int k, stim_t s);
        int  a, b, stv;
        bit  busy, luh, luh_eff;
        if (s.r) return 9'd0;
        busy = (busy_left[k] > 0) || (s.md && lat[k] > 1);
        luh  = s.mr && s.erd != 0 && (s.erd == s.irs || (s.urt && s.erd == s.irt));
        luh_eff = luh && !busy;
        a = src_of(k, s.ers);
        b = src_of(k, s.ert);
        stv = s.mw ? b : 0;
        return {a[1:0], b[1:0], stv[1:0], luh_eff || busy, luh_eff, busy};
    endfunction

    function automatic void advance(int k, stim_t s);
        bit busy;
        if (s.r) begin
            mem_s[k] = '{0, 1'b0, 1'b0};
            wb_s[k]  = '{0, 1'b0, 1'b0};
            busy_left[k] = 0;
        end else begin
            busy = (busy_left[k] > 0) || (s.md && lat[k] > 1);
            wb_s[k]  = mem_s[k];
            mem_s[k] = busy ? '{0, 1'b0, 1'b0} : '{s.erd, s.rw, s.mr};
            if (busy_left[k] > 0) busy_left[k]--;
            else if (s.md && lat[k] > 1) busy_left[k] = lat[k] - 1;
        end
    endfunction

    task automatic drive(stim_t s);
        exp_t e;
        rst = s.r;
        ex_rs = AW'(s.ers); ex_rt = AW'(s.ert); ex_rd = AW'(s.erd);
        ex_regwrite = s.rw; ex_memread = s.mr; ex_memwrite = s.mw; ex_md_start = s.md;
        id_rs = AW'(s.irs); id_rt = AW'(s.irt); id_uses_rt = s.urt;
        e.exp0 = predict(0, s);
        e.exp1 = predict(1, s);
        e.idx  = cyc;
        exp_q.push_back(e);
        advance(0, s);
        advance(1, s);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // monitor: one output set per cycle, sampled on the falling edge
    initial begin
        exp_t e;
        logic [8:0] got0, got1;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got0 = {fa0, fb0, fs0, st0, bu0, mb0};
                got1 = {fa1, fb1, fs1, st1, bu1, mb1};
                tests++;
                if (got0 !== e.exp0) begin
                    fails++;
                    $display("FAIL dut cyc=%0d got a/b/st/stall/bub/busy=%b required=%b",
                             e.idx, got0, e.exp0);
                end
                tests++;
                if (got1 !== e.exp1) begin
                    fails++;
                    $display("FAIL dut_nowb cyc=%0d got a/b/st/stall/bub/busy=%b required=%b",
                             e.idx, got1, e.exp1);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset
        drive(mk(0,0,0, 0,0,0,0, 0,0,0, 1));
        drive(mk(0,0,0, 0,0,0,0, 0,0,0, 1));
        // addi $8 ; add $9,$8,$8
        drive(mk(0,0,8, 1,0,0,0, 8,8,1, 0));
        drive(mk(8,8,9, 1,0,0,0, 0,0,0, 0));
        // addi $8 ; nop ; sw $8,0($9)
        drive(mk(0,0,8, 1,0,0,0, 0,0,0, 0));
        drive(mk(0,0,0, 0,0,0,0, 9,8,1, 0));
        drive(mk(9,8,0, 0,0,1,0, 0,0,0, 0));
        // lw $8 ; add $9,$8,$0 (stall one cycle, then MEM/WB forward)
        drive(mk(0,0,8, 1,1,0,0, 8,0,1, 0));
        drive(mk(0,0,0, 0,0,0,0, 8,0,1, 0));
        drive(mk(8,0,9, 1,0,0,0, 0,0,0, 0));
        // lw $8 ; addi $9,$10,5 with id_rt=8 not used
        drive(mk(0,0,8, 1,1,0,0, 10,8,0, 0));
        // mul held in EX for its latency, then retires, then dependent add
        for (int i = 0; i < 4; i++) drive(mk(1,2,8, 1,0,0,1, 8,8,1, 0));
        drive(mk(1,2,8, 1,0,0,0, 8,8,1, 0));
        drive(mk(8,3,9, 1,0,0,0, 0,0,0, 0));
        // reset on the second busy cycle, then a fresh full mul/div
        drive(mk(1,2,8, 1,0,0,1, 0,0,0, 0));
        drive(mk(1,2,8, 1,0,0,1, 0,0,0, 1));
        for (int i = 0; i < 5; i++) drive(mk(1,2,8, 1,0,0,(i < 4), 0,0,0, 0));
        // $0 destination never forwards or stalls
        drive(mk(0,0,0, 1,1,0,0, 0,0,1, 0));
        drive(mk(0,0,0, 1,0,1,0, 0,0,1, 0));
        // randomized traffic on a small register window to provoke matches
        for (int i = 0; i < 3000; i++) begin
            drive(mk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
                     $urandom_range(0,1), ($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0),
                     ($urandom_range(0,11) == 0), $urandom_range(0,3), $urandom_range(0,3),
                     $urandom_range(0,1), ($urandom_range(0,59) == 0)));
        end
        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
